// File: rtl/axis_tdest_demux_if.sv
// AXI4-Stream bundle carrying N parallel lanes; N=1 for a single stream,
// N=M_COUNT for the demux output side (each field is N slices wide).
interface axis_tdest_demux_if #(
  parameter int N          = 1,
  parameter int DATA_WIDTH = 8,
  parameter int KEEP_WIDTH = 1,
  parameter int ID_WIDTH   = 8,
  parameter int DEST_WIDTH = 8,
  parameter int USER_WIDTH = 1
);
  logic [N*DATA_WIDTH-1:0] tdata;
  logic [N*KEEP_WIDTH-1:0] tkeep;
  logic [N-1:0]            tvalid;
  logic [N-1:0]            tready;
  logic [N-1:0]            tlast;
  logic [N*ID_WIDTH-1:0]   tid;
  logic [N*DEST_WIDTH-1:0] tdest;
  logic [N*USER_WIDTH-1:0] tuser;

  modport master (
    output tdata, tkeep, tvalid, tlast, tid, tdest, tuser,
    input  tready
  );

  modport slave (
    input  tdata, tkeep, tvalid, tlast, tid, tdest, tuser,
    output tready
  );
endinterface

// File: rtl/axis_tdest_demux.sv
// AXI4-Stream frame demux: routes each frame to the port named by its first
// beat's tdest, discards out-of-range frames; registered output with skid.
module axis_tdest_demux #(
  parameter int M_COUNT     = 4,
  parameter int DATA_WIDTH  = 8,
  parameter bit KEEP_ENABLE = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH  = (DATA_WIDTH / 8),
  parameter bit ID_ENABLE   = 1'b0,
  parameter int ID_WIDTH    = 8,
  parameter int DEST_WIDTH  = 8,
  parameter bit USER_ENABLE = 1'b1,
  parameter int USER_WIDTH  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  axis_tdest_demux_if.slave    s_axis,
  axis_tdest_demux_if.master   m_axis
);

  localparam int SEL_W = (M_COUNT > 1) ? $clog2(M_COUNT) : 1;
  localparam int CMP_W = (DEST_WIDTH > 32) ? DEST_WIDTH : 32;

  logic             frame_q, frame_d;
  logic [SEL_W-1:0] select_q, select_d;
  logic             drop_q, drop_d;
  logic [SEL_W-1:0] cur_sel;
  logic             cur_drop;
  logic [CMP_W-1:0] dest_ext;
  logic             s_ready, s_accept, int_valid;

  logic             ready_int_q, ready_int_early;
  logic             out_valid_q, out_valid_d;
  logic             temp_valid_q, temp_valid_d;
  logic [SEL_W-1:0] out_sel_q, temp_sel_q;
  logic             out_ready;
  logic             load_out_in, load_temp_in, load_out_temp;

  logic [DATA_WIDTH-1:0] in_data, out_data_q, temp_data_q;
  logic [KEEP_WIDTH-1:0] in_keep, out_keep_q, temp_keep_q;
  logic                  in_last, out_last_q, temp_last_q;
  logic [ID_WIDTH-1:0]   in_id, out_id_q, temp_id_q;
  logic [DEST_WIDTH-1:0] in_dest, out_dest_q, temp_dest_q;
  logic [USER_WIDTH-1:0] in_user, out_user_q, temp_user_q;

  assign in_data = s_axis.tdata;
  assign in_keep = KEEP_ENABLE ? s_axis.tkeep : '1;
  assign in_last = s_axis.tlast[0];
  assign in_id   = ID_ENABLE ? s_axis.tid : '0;
  assign in_dest = s_axis.tdest;
  assign in_user = USER_ENABLE ? s_axis.tuser : '0;

  // Range check at full width so large tdest values are not aliased onto a port.
  assign dest_ext = CMP_W'(s_axis.tdest);

  always_comb begin
    if (frame_q) begin
      cur_sel  = select_q;
      cur_drop = drop_q;
    end else begin
      cur_sel  = s_axis.tdest[SEL_W-1:0];
      cur_drop = (dest_ext >= CMP_W'(M_COUNT));
    end
  end

  assign s_ready        = cur_drop || ready_int_q;
  assign s_axis.tready  = s_ready;
  assign s_accept       = s_axis.tvalid[0] && s_ready;
  assign int_valid      = s_axis.tvalid[0] && ready_int_q && !cur_drop;

  always_comb begin
    frame_d  = frame_q;
    select_d = select_q;
    drop_d   = drop_q;
    if (s_accept) begin
      if (!frame_q) begin
        select_d = cur_sel;
        drop_d   = cur_drop;
        frame_d  = !in_last;
      end else if (in_last) begin
        frame_d = 1'b0;
      end
    end
  end

  assign out_ready       = m_axis.tready[out_sel_q];
  assign ready_int_early = out_ready || (!temp_valid_q && (!out_valid_q || !int_valid));

  always_comb begin
    out_valid_d   = out_valid_q;
    temp_valid_d  = temp_valid_q;
    load_out_in   = 1'b0;
    load_temp_in  = 1'b0;
    load_out_temp = 1'b0;
    if (ready_int_q) begin
      if (out_ready || !out_valid_q) begin
        out_valid_d = int_valid;
        load_out_in = 1'b1;
      end else begin
        temp_valid_d = int_valid;
        load_temp_in = 1'b1;
      end
    end else if (out_ready) begin
      out_valid_d   = temp_valid_q;
      temp_valid_d  = 1'b0;
      load_out_temp = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_q      <= 1'b0;
      select_q     <= '0;
      drop_q       <= 1'b0;
      ready_int_q  <= 1'b0;
      out_valid_q  <= 1'b0;
      temp_valid_q <= 1'b0;
      out_sel_q    <= '0;
      temp_sel_q   <= '0;
    end else begin
      frame_q      <= frame_d;
      select_q     <= select_d;
      drop_q       <= drop_d;
      ready_int_q  <= ready_int_early;
      out_valid_q  <= out_valid_d;
      temp_valid_q <= temp_valid_d;
      if (load_out_in) begin
        out_sel_q <= cur_sel;
      end else if (load_out_temp) begin
        out_sel_q <= temp_sel_q;
      end
      if (load_temp_in) begin
        temp_sel_q <= cur_sel;
      end
    end
  end

  // Payload registers carry no reset; they are only observed while valid.
  always_ff @(posedge clk) begin
    if (load_out_in) begin
      out_data_q <= in_data;
      out_keep_q <= in_keep;
      out_last_q <= in_last;
      out_id_q   <= in_id;
      out_dest_q <= in_dest;
      out_user_q <= in_user;
    end else if (load_out_temp) begin
      out_data_q <= temp_data_q;
      out_keep_q <= temp_keep_q;
      out_last_q <= temp_last_q;
      out_id_q   <= temp_id_q;
      out_dest_q <= temp_dest_q;
      out_user_q <= temp_user_q;
    end
    if (load_temp_in) begin
      temp_data_q <= in_data;
      temp_keep_q <= in_keep;
      temp_last_q <= in_last;
      temp_id_q   <= in_id;
      temp_dest_q <= in_dest;
      temp_user_q <= in_user;
    end
  end

  assign m_axis.tvalid = {{(M_COUNT-1){1'b0}}, out_valid_q} << out_sel_q;
  assign m_axis.tdata  = {M_COUNT{out_data_q}};
  assign m_axis.tkeep  = {M_COUNT{out_keep_q}};
  assign m_axis.tlast  = {M_COUNT{out_last_q}};
  assign m_axis.tid    = {M_COUNT{out_id_q}};
  assign m_axis.tdest  = {M_COUNT{out_dest_q}};
  assign m_axis.tuser  = {M_COUNT{out_user_q}};

endmodule

// File: tb/tb_axis_tdest_demux.sv
// Scoreboard bench for axis_tdest_demux (M_COUNT=4, 8-bit data, tuser on).
module tb_axis_tdest_demux;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axis_tdest_demux_if #(.N(1), .DATA_WIDTH(8), .KEEP_WIDTH(1), .ID_WIDTH(8),
                        .DEST_WIDTH(8), .USER_WIDTH(1)) s_if ();
  axis_tdest_demux_if #(.N(4), .DATA_WIDTH(8), .KEEP_WIDTH(1), .ID_WIDTH(8),
                        .DEST_WIDTH(8), .USER_WIDTH(1)) m_if ();

  axis_tdest_demux #(
    .M_COUNT(4), .DATA_WIDTH(8), .KEEP_ENABLE(1'b0), .KEEP_WIDTH(1),
    .ID_ENABLE(1'b0), .ID_WIDTH(8), .DEST_WIDTH(8), .USER_ENABLE(1'b1), .USER_WIDTH(1)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .s_axis (s_if.slave),
    .m_axis (m_if.master)
  );

  typedef struct {
    int         port;
    logic [7:0] data;
    logic       last;
    logic [7:0] dest;
    int         acc;
    bit         strict;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   fails  = 0;
  int   cyc    = 0;

  logic [3:0]  mr_base   = 4'b1111;
  logic        toggle_en = 1'b0;
  logic        tgl       = 1'b0;
  logic [15:0] pat       = 16'b1011_0010_1101_0011;
  int          k         = 0;

  assign m_if.tready = toggle_en ? {mr_base[3:1], tgl} : mr_base;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      tgl = pat[k % 16];
      k++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expected beat per output handshake.
  always @(negedge clk) begin
    if (!rst) begin
      chk("onehot_valid", 32'($countones(m_if.tvalid) <= 1), 1);
      for (int p = 0; p < 4; p++) begin
        if (m_if.tvalid[p] && m_if.tready[p]) begin
          if (sb.size() == 0) begin
            chk("unexpected_beat_port", p, 32'hFFFF);
          end else begin
            e = sb.pop_front();
            chk("out_port", p, e.port);
            chk("out_data", m_if.tdata[p*8 +: 8], e.data);
            chk("out_last", m_if.tlast[p], e.last);
            chk("out_dest", m_if.tdest[p*8 +: 8], e.dest);
            chk("out_user", m_if.tuser[p], e.data[0]);
            chk("out_keep", m_if.tkeep[p], 1);
            chk("out_id", m_if.tid[p*8 +: 8], 0);
            if (e.strict) chk("latency", cyc - e.acc, 1);
          end
        end
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic [7:0] dest, input logic last,
                      input int port, input bit strict, output int waited);
    bit done = 0;
    s_if.tdata  = d;
    s_if.tdest  = dest;
    s_if.tlast  = last;
    s_if.tuser  = d[0];
    s_if.tkeep  = '1;
    s_if.tid    = d;
    s_if.tvalid = 1'b1;
    waited = 0;
    while (!done && waited < 100) begin
      @(negedge clk);
      if (s_if.tready[0]) begin
        done = 1;
        if (port < 0) chk("drop_no_valid", m_if.tvalid, 0);
        else sb.push_back('{port, d, last, dest, cyc, strict});
      end else begin
        waited++;
      end
    end
    if (!done) chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    s_if.tvalid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int w;
    logic [7:0] dl [4];
    logic [7:0] dd [4];
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    s_if.tdest  = '0;
    s_if.tlast  = 1'b0;
    s_if.tuser  = '0;
    s_if.tkeep  = '1;
    s_if.tid    = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_tvalid", m_if.tvalid, 0);
    chk("reset_s_tready", s_if.tready, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("first_cycle_s_tready", s_if.tready, 0);
    s_if.tdest = 8'd5;
    #1 chk("first_cycle_drop_tready", s_if.tready, 1);
    s_if.tdest = 8'd0;
    @(posedge clk);
    #1;

    // 3-beat frame to port 2
    send(8'hA0, 8'd2, 1'b0, 2, 1, w); chk("t1_wait0", w, 0);
    send(8'hA1, 8'd2, 1'b0, 2, 1, w); chk("t1_wait1", w, 0);
    send(8'hA2, 8'd2, 1'b1, 2, 1, w); chk("t1_wait2", w, 0);
    drain();

    // Back-to-back single-beat frames to 0,1,3,0
    dd = '{8'd0, 8'd1, 8'd3, 8'd0};
    dl = '{8'hB0, 8'hB1, 8'hB2, 8'hB3};
    for (int i = 0; i < 4; i++) begin
      send(dl[i], dd[i], 1'b1, int'(dd[i]), 1, w);
      chk("t2_wait", w, 0);
    end
    drain();

    // tdest changes mid-frame; frame stays on port 1
    dd = '{8'd1, 8'd3, 8'd3, 8'd3};
    for (int i = 0; i < 4; i++) begin
      send(8'hC0 + 8'(i), dd[i], (i == 3), 1, 1, w);
      chk("t3_wait", w, 0);
    end
    drain();

    // Out-of-range frames dropped even with all outputs stalled
    mr_base = 4'b0000;
    send(8'hD0, 8'd5, 1'b0, -1, 0, w); chk("t4_wait0", w, 0);
    send(8'hD1, 8'd5, 1'b0, -1, 0, w); chk("t4_wait1", w, 0);
    send(8'hD2, 8'd5, 1'b1, -1, 0, w); chk("t4_wait2", w, 0);
    send(8'hD3, 8'd4, 1'b1, -1, 0, w); chk("t4_wait_eq4", w, 0);
    send(8'hD4, 8'h84, 1'b1, -1, 0, w); chk("t4_wait_84", w, 0);
    @(negedge clk);
    chk("t4_no_valid", m_if.tvalid, 0);
    mr_base = 4'b1111;
    @(posedge clk);
    #1;

    // Backpressure on port 0, then pseudo-random ready toggling
    mr_base = 4'b1110;
    send(8'h10, 8'd0, 1'b0, 0, 0, w); chk("t5_wait_10", w, 0);
    send(8'h11, 8'd0, 1'b0, 0, 0, w); chk("t5_wait_11", w, 0);
    fork
      begin
        send(8'h12, 8'd0, 1'b0, 0, 0, w);
        chk("t5_stall_12", 32'(w > 0), 1);
      end
      begin
        repeat (3) @(posedge clk);
        #1 toggle_en = 1'b1;
      end
    join
    for (int i = 3; i < 8; i++) send(8'h10 + 8'(i), 8'd0, (i == 7), 0, 0, w);
    drain();
    toggle_en = 1'b0;
    mr_base   = 4'b1111;

    // Reset mid-frame with beats held in output and skid registers
    mr_base = 4'b1011;
    send(8'hE0, 8'd2, 1'b0, 2, 0, w);
    send(8'hE1, 8'd2, 1'b0, 2, 0, w); chk("t6_wait_e1", w, 0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t6_reset_tvalid", m_if.tvalid, 0);
    sb.delete();
    mr_base = 4'b1111;
    @(posedge clk);
    #1 rst = 1'b0;
    send(8'hF0, 8'd0, 1'b1, 0, 1, w); chk("t6_wait_after_reset", w, 1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
